// File: rtl/ram_scan_reader_pkg.sv
// Shared types and constants for the read-side sweep engine.
package ram_scan_pkg;

  localparam int NUM_RPORTS     = 8;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } state_e;

  function automatic int addr_width(input int blocksize);
    return blocksize + 1;
  endfunction

endpackage

// File: rtl/ram_scan_reader_lane_buffer.sv
// Captures one 8-word read group and serialises its valid lanes onto a valid/ready stream.
module scan_lane_buffer
  import ram_scan_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                capture_i,
  input  logic [3:0]                          lanes_i,
  input  logic                                final_i,
  input  logic [NUM_RPORTS-1:0][DATA_W-1:0]   data_i,
  input  logic                                ready_i,
  output logic [DATA_W-1:0]                   data_o,
  output logic                                valid_o,
  output logic                                last_o,
  output logic                                grp_done_o
);

  logic [DATA_W-1:0] buf_q [NUM_RPORTS];
  logic [2:0]        ptr_q, ptr_d;
  logic [3:0]        lanes_q;
  logic              final_q;
  logic              active_q, active_d;
  logic              last_lane;
  logic              fire;

  assign last_lane  = ({1'b0, ptr_q} == (lanes_q - 4'd1));
  assign fire       = active_q & ready_i;
  assign grp_done_o = fire & last_lane;
  assign valid_o    = active_q;
  assign data_o     = buf_q[ptr_q];
  assign last_o     = active_q & final_q & last_lane;

  always_comb begin
    ptr_d    = ptr_q;
    active_d = active_q;
    if (capture_i) begin
      ptr_d    = '0;
      active_d = 1'b1;
    end else if (fire) begin
      // Lanes beyond lanes_q in a partial group are skipped by closing here.
      ptr_d    = last_lane ? 3'd0 : ptr_q + 3'd1;
      active_d = ~last_lane;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RPORTS; i++) buf_q[i] <= '0;
      ptr_q    <= '0;
      lanes_q  <= '0;
      final_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      active_q <= active_d;
      if (capture_i) begin
        for (int i = 0; i < NUM_RPORTS; i++) buf_q[i] <= data_i[i];
        lanes_q <= lanes_i;
        final_q <= final_i;
      end
    end
  end

endmodule

// File: rtl/ram_scan_reader.sv
// Sweeps an address range through eight parallel read ports and streams the words out in order.
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int BLOCKSIZE = 10,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BLOCKSIZE:0]   base_addr,
  input  logic [BLOCKSIZE+1:0] count,
  output logic                 busy,
  output logic                 done,
  output logic [BLOCKSIZE:0]   r1_addr,
  output logic [BLOCKSIZE:0]   r2_addr,
  output logic [BLOCKSIZE:0]   r3_addr,
  output logic [BLOCKSIZE:0]   r4_addr,
  output logic [BLOCKSIZE:0]   r5_addr,
  output logic [BLOCKSIZE:0]   r6_addr,
  output logic [BLOCKSIZE:0]   r7_addr,
  output logic [BLOCKSIZE:0]   r8_addr,
  input  logic [DATA_W-1:0]    d1,
  input  logic [DATA_W-1:0]    d2,
  input  logic [DATA_W-1:0]    d3,
  input  logic [DATA_W-1:0]    d4,
  input  logic [DATA_W-1:0]    d5,
  input  logic [DATA_W-1:0]    d6,
  input  logic [DATA_W-1:0]    d7,
  input  logic [DATA_W-1:0]    d8,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int AW    = addr_width(BLOCKSIZE);
  localparam int CW    = AW + 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_e                 state_q, state_d;
  logic [AW-1:0]          grp_addr_q, grp_addr_d;
  logic [CW-1:0]          remaining_q, remaining_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [AW-1:0]          raddr_q [NUM_RPORTS];
  logic [3:0]             lanes_now;
  logic                   capture;
  logic                   grp_done;
  logic [NUM_RPORTS-1:0][DATA_W-1:0] d_bus;

  assign d_bus = {d8, d7, d6, d5, d4, d3, d2, d1};
  assign {r8_addr, r7_addr, r6_addr, r5_addr, r4_addr, r3_addr, r2_addr, r1_addr} =
    {raddr_q[7], raddr_q[6], raddr_q[5], raddr_q[4],
     raddr_q[3], raddr_q[2], raddr_q[1], raddr_q[0]};

  assign lanes_now = (remaining_q >= CW'(NUM_RPORTS)) ? 4'd8 : remaining_q[3:0];

  always_comb begin
    state_d     = state_q;
    grp_addr_d  = grp_addr_q;
    remaining_d = remaining_q;
    lat_d       = lat_q;
    capture     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_d = DONE;
          end else begin
            grp_addr_d  = base_addr;
            remaining_d = (count > DEPTH) ? DEPTH : count;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        busy    = 1'b1;
        lat_d   = LAT_W'(RD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_q == '0) begin
          capture     = 1'b1;
          remaining_d = remaining_q - CW'(lanes_now);
          grp_addr_d  = grp_addr_q + AW'(NUM_RPORTS);
          state_d     = DRAIN;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (grp_done) state_d = (remaining_q != '0) ? ISSUE : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grp_addr_q  <= '0;
      remaining_q <= '0;
      lat_q       <= '0;
      for (int i = 0; i < NUM_RPORTS; i++) raddr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      grp_addr_q  <= grp_addr_d;
      remaining_q <= remaining_d;
      lat_q       <= lat_d;
      // Lane addresses move only when entering ISSUE and hold through WAIT/DRAIN.
      if (state_d == ISSUE) begin
        for (int i = 0; i < NUM_RPORTS; i++) raddr_q[i] <= grp_addr_d + AW'(i);
      end
    end
  end

  scan_lane_buffer #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .capture_i  (capture),
    .lanes_i    (lanes_now),
    .final_i    (remaining_q == CW'(lanes_now)),
    .data_i     (d_bus),
    .ready_i    (out_ready),
    .data_o     (out_data),
    .valid_o    (out_valid),
    .last_o     (out_last),
    .grp_done_o (grp_done)
  );

endmodule

// File: tb/tb_ram_scan_reader.sv
// Scoreboard bench for ram_scan_reader against a registered-read memory model holding mem[a]=a*3.
module tb_ram_scan_reader;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 2048;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy, done;
  logic [AW-1:0] r1_addr, r2_addr, r3_addr, r4_addr, r5_addr, r6_addr, r7_addr, r8_addr;
  logic [DW-1:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b1;
  logic          rand_ready = 1'b0;

  always #5 clk = ~clk;

  ram_scan_reader #(.BLOCKSIZE(10), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .r3_addr(r3_addr), .r4_addr(r4_addr),
    .r5_addr(r5_addr), .r6_addr(r6_addr), .r7_addr(r7_addr), .r8_addr(r8_addr),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  logic [AW-1:0] raddr [8];
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dq [8];

  assign raddr[0] = r1_addr; assign raddr[1] = r2_addr;
  assign raddr[2] = r3_addr; assign raddr[3] = r4_addr;
  assign raddr[4] = r5_addr; assign raddr[5] = r6_addr;
  assign raddr[6] = r7_addr; assign raddr[7] = r8_addr;
  assign {d8, d7, d6, d5, d4, d3, d2, d1} = {dq[7], dq[6], dq[5], dq[4], dq[3], dq[2], dq[1], dq[0]};

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) dq[k] <= mem[raddr[k]];
  end

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_xfer_cyc = -10;
  int   xfer_cnt = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops one expected word per transfer and checks stall stability.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  exp_t          e;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(out_valid === 1'b1 && out_data === prev_data && out_last === prev_last)) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%0d last=%0b expected valid=1 data=%0d last=%0b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data=%0d last=%0b expected no transfer", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL word: got data=%0d last=%0b expected data=%0d last=%0b",
                     out_data, out_last, e.data, e.last);
          end
        end
        xfer_cnt++;
        if (out_last) last_xfer_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic push_expected(input logic [AW-1:0] b, input int cnt);
    int n;
    logic [AW-1:0] a;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      exp_q.push_back(exp_t'{data: mem[a], last: (i == n - 1)});
    end
  endtask

  task automatic run_scan(input logic [AW-1:0] b, input int cnt,
                          input bit chk_first, input bit chk_addr, input bit glitch);
    logic [AW-1:0] ea;
    bit finished;
    finished = 1'b0;
    push_expected(b, cnt);
    @(negedge clk);
    base_addr = b;
    count     = (AW+1)'(cnt);
    start     = 1'b1;
    for (int k = 1; k <= 20000 && !finished; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (glitch && k == 4) begin
        base_addr = 11'd500;
        count     = 12'd3;
        start     = 1'b1;
      end
      if (glitch && k == 5) start = 1'b0;
      if (chk_first && (k == 1 || k == 2)) chk("early_valid", 64'(out_valid), 64'd0);
      if (chk_first && k == 3) chk("first_valid_cycle3", 64'(out_valid), 64'd1);
      if (chk_addr && k == 1) begin
        for (int j = 0; j < 8; j++) begin
          ea = b + AW'(j);
          chk($sformatf("issue_addr_lane%0d", j + 1), 64'(raddr[j]), 64'(ea));
        end
      end
      if (done) begin
        finished = 1'b1;
        if (cnt == 0) chk("done_after_start", 64'(k), 64'd1);
        else          chk("done_after_last", 64'(cyc), 64'(last_xfer_cyc + 1));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
        $display("scan base=%0d count=%0d done after %0d cycles", b, cnt, k);
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 20000 cycles");
    end
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    for (int j = 0; j < 8; j++) chk($sformatf("rst_addr%0d", j + 1), 64'(raddr[j]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_scan(11'd0,    16,   1'b1, 1'b1, 1'b0);
    run_scan(11'd2044, 8,    1'b0, 1'b1, 1'b0);
    run_scan(11'd7,    5,    1'b0, 1'b0, 1'b0);
    rand_ready = 1'b1;
    run_scan(11'd30,   20,   1'b0, 1'b0, 1'b0);
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);
    run_scan(11'd9,    0,    1'b0, 1'b0, 1'b0);
    run_scan(11'd50,   40,   1'b0, 1'b0, 1'b1);
    run_scan(11'd3,    4000, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the second group's drain.
    push_expected(11'd0, 16);
    @(negedge clk);
    base_addr = 11'd0;
    count     = 12'd16;
    start     = 1'b1;
    begin
      int base_x;
      bit reached;
      base_x  = xfer_cnt;
      reached = 1'b0;
      for (int k = 1; k <= 200 && !reached; k++) begin
        @(negedge clk);
        if (k == 1) start = 1'b0;
        if (xfer_cnt >= base_x + 10) reached = 1'b1;
      end
      if (!reached) begin
        checks++;
        errors++;
        $display("FAIL reset_reach_group2: got %0d transfers expected 10", xfer_cnt - base_x);
      end
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_last", 64'(out_last), 64'd0);
    for (int j = 0; j < 8; j++) chk($sformatf("midrst_addr%0d", j + 1), 64'(raddr[j]), 64'd0);
    exp_q.delete();
    $display("reset applied mid-scan");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_scan(11'd100, 8, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
